// File: rtl/comms_pkg.sv
// Shared definitions for the encrypted comms line: sync byte, receiver FSM
// states and the key rotation used by both transmitter and receiver.
package comms_pkg;

   localparam logic [7:0] SYNC_BYTE = 8'hA5;

   typedef enum logic [1:0] {
      IDLE,
      LEN,
      PAYLOAD,
      CHECK
   } rx_state_t;

   // Key schedule: rotate left by one bit per payload byte.
   function automatic logic [7:0] rotl1(input logic [7:0] k);
      return {k[6:0], k[7]};
   endfunction

endpackage

// File: rtl/rx_fifo.sv
// Small synchronous FIFO for decrypted bytes; head is always visible on
// o_head, with no write-to-read bypass.
module rx_fifo #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = 8
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_pop,
   output logic             o_full,
   output logic             o_empty,
   output logic [WIDTH-1:0] o_head
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [AW:0]      r_count;

   logic w_pop;
   logic w_push;

   assign o_full  = (r_count == FULL_CNT);
   assign o_empty = (r_count == '0);
   assign o_head  = r_mem[r_rd_ptr];

   // A push into a full FIFO is accepted only when a pop frees a slot in the same cycle.
   assign w_pop  = i_pop && !o_empty;
   assign w_push = i_push && (!o_full || w_pop);

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_mem    <= '{default: '0};
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
            r_wr_ptr        <= r_wr_ptr + 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/xor_frame_receiver.sv
// Framed XOR-decrypting receiver: sync search, length, rotating-key payload
// decryption with plaintext checksum, and a valid/ready output FIFO.
module xor_frame_receiver
   import comms_pkg::*;
#(
   parameter int unsigned DEPTH = 4,
   parameter logic [7:0]  SYNC  = SYNC_BYTE
) (
   input  logic       clk_bar,
   input  logic       clr,
   input  logic [7:0] line_data,
   input  logic       line_valid,
   input  logic [7:0] key_out,
   input  logic       out_ready,
   output logic [7:0] data_out,
   output logic       data_valid,
   output logic       frame_done,
   output logic       frame_err,
   output logic       busy
);

   rx_state_t  r_state;
   logic [7:0] r_key;
   logic [7:0] r_csum;
   logic [7:0] r_len;
   logic       r_ovf;
   logic       r_done;
   logic       r_err;

   rx_state_t  w_state_nxt;
   logic [7:0] w_key_nxt;
   logic [7:0] w_csum_nxt;
   logic [7:0] w_len_nxt;
   logic       w_ovf_nxt;
   logic       w_done_nxt;
   logic       w_err_nxt;

   logic [7:0] w_plain;
   logic       w_push;
   logic       w_pop;
   logic       w_full;
   logic       w_empty;

   assign w_plain    = line_data ^ r_key;
   assign w_pop      = data_valid && out_ready;
   assign data_valid = !w_empty;
   assign busy       = (r_state != IDLE);
   assign frame_done = r_done;
   assign frame_err  = r_err;

   rx_fifo #(
      .DEPTH(DEPTH),
      .WIDTH(8)
   ) u_fifo (
      .i_clk  (clk_bar),
      .i_rst  (clr),
      .i_push (w_push),
      .i_data (w_plain),
      .i_pop  (w_pop),
      .o_full (w_full),
      .o_empty(w_empty),
      .o_head (data_out)
   );

   always_ff @(posedge clk_bar or posedge clr) begin
      if (clr) begin
         r_state <= IDLE;
         r_key   <= '0;
         r_csum  <= '0;
         r_len   <= '0;
         r_ovf   <= 1'b0;
         r_done  <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_key   <= w_key_nxt;
         r_csum  <= w_csum_nxt;
         r_len   <= w_len_nxt;
         r_ovf   <= w_ovf_nxt;
         r_done  <= w_done_nxt;
         r_err   <= w_err_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_key_nxt   = r_key;
      w_csum_nxt  = r_csum;
      w_len_nxt   = r_len;
      w_ovf_nxt   = r_ovf;
      w_done_nxt  = 1'b0;
      w_err_nxt   = 1'b0;
      w_push      = 1'b0;

      if (line_valid) begin
         case (r_state)
            IDLE: begin
               if (line_data == SYNC) begin
                  w_state_nxt = LEN;
               end
            end
            LEN: begin
               w_len_nxt  = line_data;
               w_key_nxt  = key_out;
               w_csum_nxt = '0;
               w_ovf_nxt  = 1'b0;
               if (line_data == '0) begin
                  w_err_nxt   = 1'b1;
                  w_state_nxt = IDLE;
               end else begin
                  w_state_nxt = PAYLOAD;
               end
            end
            PAYLOAD: begin
               w_push     = 1'b1;
               w_key_nxt  = rotl1(r_key);
               w_csum_nxt = r_csum ^ w_plain;
               // Dropped byte still advances key and checksum so the frame stays aligned.
               if (w_full && !w_pop) begin
                  w_ovf_nxt = 1'b1;
               end
               w_len_nxt = r_len - 8'd1;
               if (r_len == 8'd1) begin
                  w_state_nxt = CHECK;
               end
            end
            CHECK: begin
               if ((line_data == r_csum) && !r_ovf) begin
                  w_done_nxt = 1'b1;
               end else begin
                  w_err_nxt = 1'b1;
               end
               w_state_nxt = IDLE;
            end
            default: begin
               w_state_nxt = IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_xor_frame_receiver.sv
// Directed bench for xor_frame_receiver with hand-computed expected bytes.
module tb_xor_frame_receiver;

   logic       clk_bar = 1'b0;
   logic       clr;
   logic [7:0] line_data;
   logic       line_valid;
   logic [7:0] key_out;
   logic       out_ready;
   logic [7:0] data_out;
   logic       data_valid;
   logic       frame_done;
   logic       frame_err;
   logic       busy;

   logic [3:0] flags;
   assign flags = {data_valid, busy, frame_done, frame_err};

   int vectors     = 0;
   int miscompares = 0;

   // key 0x3C, plaintext 01..06, checksum 07
   logic [7:0] ovf_cipher [6] = '{8'h3D, 8'h7A, 8'hF3, 8'hE5, 8'hC6, 8'h81};
   logic [7:0] ovf_plain  [4] = '{8'h01, 8'h02, 8'h03, 8'h04};
   logic [7:0] pp_plain   [4] = '{8'h20, 8'h30, 8'h40, 8'h50};

   always #5 clk_bar = ~clk_bar;

   xor_frame_receiver #(
      .DEPTH(4),
      .SYNC (8'hA5)
   ) dut (
      .clk_bar   (clk_bar),
      .clr       (clr),
      .line_data (line_data),
      .line_valid(line_valid),
      .key_out   (key_out),
      .out_ready (out_ready),
      .data_out  (data_out),
      .data_valid(data_valid),
      .frame_done(frame_done),
      .frame_err (frame_err),
      .busy      (busy)
   );

   task automatic step(input logic v, input logic [7:0] d);
      line_valid = v;
      line_data  = d;
      @(negedge clk_bar);
   endtask

   task automatic test_reset();
      clr = 1'b1;
      repeat (2) @(negedge clk_bar);
      vectors++;
      if ({flags, data_out} !== 12'h000) begin
         miscompares++;
         $display("FAIL reset_outputs: got %b/%h, expected 0000/00", flags, data_out);
      end
      clr = 1'b0;
      step(1'b0, 8'h00);
      vectors++;
      if ({flags, data_out} !== 12'h000) begin
         miscompares++;
         $display("FAIL reset_release: got %b/%h, expected 0000/00", flags, data_out);
      end
   endtask

   task automatic test_basic();
      key_out   = 8'h3C;
      out_ready = 1'b1;
      step(1'b1, 8'hA5);
      vectors++;
      if (flags !== 4'b0100) begin
         miscompares++;
         $display("FAIL basic_sync: got %b, expected 0100", flags);
      end
      step(1'b1, 8'h02);
      step(1'b1, 8'h74);
      vectors++;
      if ({flags, data_out} !== {4'b1100, 8'h48}) begin
         miscompares++;
         $display("FAIL basic_byte0: got %b/%h, expected 1100/48", flags, data_out);
      end
      step(1'b1, 8'h11);
      vectors++;
      if ({flags, data_out} !== {4'b1100, 8'h69}) begin
         miscompares++;
         $display("FAIL basic_byte1: got %b/%h, expected 1100/69", flags, data_out);
      end
      step(1'b1, 8'h21);
      vectors++;
      if (flags !== 4'b0010) begin
         miscompares++;
         $display("FAIL basic_done: got %b, expected 0010", flags);
      end
      step(1'b0, 8'h00);
      vectors++;
      if (flags !== 4'b0000) begin
         miscompares++;
         $display("FAIL basic_pulse_end: got %b, expected 0000", flags);
      end
   endtask

   task automatic test_bad_checksum();
      key_out   = 8'h3C;
      out_ready = 1'b1;
      step(1'b1, 8'hA5);
      step(1'b1, 8'h02);
      step(1'b1, 8'h74);
      vectors++;
      if ({flags, data_out} !== {4'b1100, 8'h48}) begin
         miscompares++;
         $display("FAIL badck_byte0: got %b/%h, expected 1100/48", flags, data_out);
      end
      step(1'b1, 8'h11);
      vectors++;
      if ({flags, data_out} !== {4'b1100, 8'h69}) begin
         miscompares++;
         $display("FAIL badck_byte1: got %b/%h, expected 1100/69", flags, data_out);
      end
      step(1'b1, 8'h22);
      vectors++;
      if (flags !== 4'b0001) begin
         miscompares++;
         $display("FAIL badck_err: got %b, expected 0001", flags);
      end
      step(1'b0, 8'h00);
      vectors++;
      if (flags !== 4'b0000) begin
         miscompares++;
         $display("FAIL badck_pulse_end: got %b, expected 0000", flags);
      end
   endtask

   task automatic test_zero_length();
      step(1'b1, 8'hA5);
      vectors++;
      if (flags !== 4'b0100) begin
         miscompares++;
         $display("FAIL zlen_sync: got %b, expected 0100", flags);
      end
      step(1'b1, 8'h00);
      vectors++;
      if (flags !== 4'b0001) begin
         miscompares++;
         $display("FAIL zlen_err: got %b, expected 0001", flags);
      end
      step(1'b0, 8'h00);
      vectors++;
      if (flags !== 4'b0000) begin
         miscompares++;
         $display("FAIL zlen_idle: got %b, expected 0000", flags);
      end
   endtask

   task automatic test_overflow();
      key_out   = 8'h3C;
      out_ready = 1'b0;
      step(1'b1, 8'hA5);
      step(1'b1, 8'h06);
      for (int i = 0; i < 6; i++) begin
         step(1'b1, ovf_cipher[i]);
      end
      vectors++;
      if ({flags, data_out} !== {4'b1100, 8'h01}) begin
         miscompares++;
         $display("FAIL ovf_full_head: got %b/%h, expected 1100/01", flags, data_out);
      end
      step(1'b1, 8'h07);
      vectors++;
      if (flags !== 4'b1001) begin
         miscompares++;
         $display("FAIL ovf_err: got %b, expected 1001", flags);
      end
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         vectors++;
         if ({data_valid, data_out} !== {1'b1, ovf_plain[i]}) begin
            miscompares++;
            $display("FAIL ovf_drain%0d: got %b/%h, expected 1/%h", i, data_valid, data_out, ovf_plain[i]);
         end
         step(1'b0, 8'h00);
      end
      vectors++;
      if (flags !== 4'b0000) begin
         miscompares++;
         $display("FAIL ovf_empty: got %b, expected 0000", flags);
      end
      out_ready = 1'b0;
   endtask

   task automatic test_full_pushpop();
      key_out   = 8'h81;
      out_ready = 1'b0;
      step(1'b1, 8'hA5);
      step(1'b1, 8'h05);
      step(1'b1, 8'h91);
      step(1'b0, 8'hFF);
      step(1'b1, 8'h23);
      step(1'b0, 8'h00);
      step(1'b0, 8'hA5);
      step(1'b1, 8'h36);
      step(1'b1, 8'h4C);
      vectors++;
      if ({flags, data_out} !== {4'b1100, 8'h10}) begin
         miscompares++;
         $display("FAIL pp_full_head: got %b/%h, expected 1100/10", flags, data_out);
      end
      out_ready = 1'b1;
      step(1'b1, 8'h48);
      out_ready = 1'b0;
      vectors++;
      if ({flags, data_out} !== {4'b1100, 8'h20}) begin
         miscompares++;
         $display("FAIL pp_pushpop: got %b/%h, expected 1100/20", flags, data_out);
      end
      step(1'b1, 8'h10);
      vectors++;
      if (flags !== 4'b1010) begin
         miscompares++;
         $display("FAIL pp_done: got %b, expected 1010", flags);
      end
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         vectors++;
         if ({data_valid, data_out} !== {1'b1, pp_plain[i]}) begin
            miscompares++;
            $display("FAIL pp_drain%0d: got %b/%h, expected 1/%h", i, data_valid, data_out, pp_plain[i]);
         end
         step(1'b0, 8'h00);
      end
      vectors++;
      if (flags !== 4'b0000) begin
         miscompares++;
         $display("FAIL pp_empty: got %b, expected 0000", flags);
      end
   endtask

   task automatic test_reset_mid();
      key_out   = 8'h3C;
      out_ready = 1'b1;
      step(1'b1, 8'hA5);
      step(1'b1, 8'h02);
      step(1'b1, 8'h74);
      vectors++;
      if ({flags, data_out} !== {4'b1100, 8'h48}) begin
         miscompares++;
         $display("FAIL rstmid_pre: got %b/%h, expected 1100/48", flags, data_out);
      end
      line_valid = 1'b0;
      #1 clr = 1'b1;
      #1;
      vectors++;
      if ({flags, data_out} !== 12'h000) begin
         miscompares++;
         $display("FAIL rstmid_async: got %b/%h, expected 0000/00", flags, data_out);
      end
      @(negedge clk_bar);
      clr = 1'b0;
      step(1'b0, 8'h00);
      vectors++;
      if ({flags, data_out} !== 12'h000) begin
         miscompares++;
         $display("FAIL rstmid_nopulse: got %b/%h, expected 0000/00", flags, data_out);
      end
      test_basic();
   endtask

   task automatic test_back_to_back();
      key_out   = 8'h3C;
      out_ready = 1'b1;
      step(1'b1, 8'hA5);
      step(1'b1, 8'h02);
      step(1'b1, 8'h74);
      step(1'b1, 8'h11);
      step(1'b1, 8'h21);
      vectors++;
      if (flags !== 4'b0010) begin
         miscompares++;
         $display("FAIL b2b_done1: got %b, expected 0010", flags);
      end
      key_out = 8'h01;
      step(1'b1, 8'hA5);
      vectors++;
      if (flags !== 4'b0100) begin
         miscompares++;
         $display("FAIL b2b_sync2: got %b, expected 0100", flags);
      end
      step(1'b1, 8'h01);
      step(1'b1, 8'hAB);
      vectors++;
      if ({flags, data_out} !== {4'b1100, 8'hAA}) begin
         miscompares++;
         $display("FAIL b2b_byte: got %b/%h, expected 1100/AA", flags, data_out);
      end
      step(1'b1, 8'hAA);
      vectors++;
      if (flags !== 4'b0010) begin
         miscompares++;
         $display("FAIL b2b_done2: got %b, expected 0010", flags);
      end
      step(1'b0, 8'h00);
   endtask

   initial begin
      clr        = 1'b1;
      line_valid = 1'b0;
      line_data  = 8'h00;
      key_out    = 8'h00;
      out_ready  = 1'b0;
      test_reset();
      test_basic();
      test_bad_checksum();
      test_zero_length();
      test_overflow();
      test_full_pushpop();
      test_reset_mid();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
